if_fetch_icache: RTL and testbench

//  Instruction-fetch stage with a direct-mapped instruction cache. Holds the PC.

---
 rtl/if_fetch_icache_pkg.sv | 20 ++
 rtl/if_fetch_icache_if.sv | 23 ++
 rtl/if_fetch_icache_icache_dm.sv | 57 +++++
 rtl/if_fetch_icache.sv | 140 ++++++++++++++
 tb/tb_if_fetch_icache.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_icache_pkg.sv
// rtl/if_fetch_icache_pkg.sv - shared bus types, state encoding and helpers for the fetch stage
package if_fetch_icache_pkg;

    typedef logic [31:0] reg_bus_t;
    typedef logic [31:0] inst_bus_t;

    localparam reg_bus_t ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    // Sequential fetch address; wraps naturally modulo 2**32.
    function automatic reg_bus_t pc_next(input reg_bus_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_icache_if.sv
// rtl/if_fetch_icache_if.sv - fetch stage to memctrl instruction-port handshake
interface if_fetch_icache_if;
    import if_fetch_icache_pkg::*;

    logic      if_req_out;
    reg_bus_t  if_addr_out;
    logic      inst_flush_out;
    logic      mc_busy_in;
    logic      mc_take_in;
    logic      mc_inst_valid_in;
    reg_bus_t  mc_pc_in;
    inst_bus_t mc_inst_in;

    modport master (
        output if_req_out, if_addr_out, inst_flush_out,
        input  mc_busy_in, mc_take_in, mc_inst_valid_in, mc_pc_in, mc_inst_in
    );

    modport slave (
        input  if_req_out, if_addr_out, inst_flush_out,
        output mc_busy_in, mc_take_in, mc_inst_valid_in, mc_pc_in, mc_inst_in
    );
endinterface

// File: rtl/if_fetch_icache_icache_dm.sv
// rtl/if_fetch_icache_icache_dm.sv - direct-mapped one-word-per-line instruction cache arrays
module icache_dm
    import if_fetch_icache_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] rd_word,
    output logic        rd_hit,
    output inst_bus_t   rd_inst,
    input  logic        wr_en,
    input  logic [29:0] wr_word,
    input  inst_bus_t   wr_inst
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem [LINES];
    inst_bus_t        inst_mem [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign rd_idx  = rd_word[IDX_W-1:0];
    assign wr_idx  = wr_word[IDX_W-1:0];
    assign rd_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_word[29:IDX_W]);
    assign rd_inst = inst_mem[rd_idx];

    // A fill marks its line valid; only reset ever clears lines.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Valid bits need a reset; tag/data arrays do not since valid gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Synchronous tag/data write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_word[29:IDX_W];
            inst_mem[wr_idx] <= wr_inst;
        end
    end

endmodule

// File: rtl/if_fetch_icache.sv
// rtl/if_fetch_icache.sv - instruction fetch stage: PC, icache lookup, miss refill via memctrl
module if_fetch_icache
    import if_fetch_icache_pkg::*;
#(
    parameter int       IDX_W  = 7,
    parameter reg_bus_t RST_PC = ZERO_WORD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_in,
    input  logic                     branch_flag_in,
    input  reg_bus_t                 branch_target_in,
    if_fetch_icache_if.master        mc,
    output logic                     if_id_valid_out,
    output reg_bus_t                 if_id_pc_out,
    output inst_bus_t                if_id_inst_out
);
    if_state_e state_q, state_d;
    reg_bus_t  pc_q, pc_d;
    reg_bus_t  req_pc_q, req_pc_d;
    reg_bus_t  if_addr_q, if_addr_d;
    reg_bus_t  if_id_pc_q, if_id_pc_d;
    inst_bus_t if_id_inst_q, if_id_inst_d;
    logic      if_req_q, if_req_d;
    logic      inst_flush_q, inst_flush_d;
    logic      if_id_valid_q, if_id_valid_d;

    logic      hit;
    inst_bus_t line_inst;
    logic      fill_accept;

    // Only a completion tagged with our own request PC counts; memctrl's
    // get_inst is a level and may still reflect an older transfer.
    assign fill_accept = (state_q == IF_WAIT) && !branch_flag_in &&
                         mc.mc_inst_valid_in && (mc.mc_pc_in == req_pc_q);

    icache_dm #(.IDX_W(IDX_W)) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_word (pc_q[31:2]),
        .rd_hit  (hit),
        .rd_inst (line_inst),
        .wr_en   (fill_accept),
        .wr_word (req_pc_q[31:2]),
        .wr_inst (mc.mc_inst_in)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a redirect always returns to IDLE; misses run REQ -> WAIT.
    always_comb begin
        state_d = state_q;
        if (branch_flag_in) begin
            state_d = IF_IDLE;
        end else begin
            case (state_q)
                IF_IDLE: if (!hit && !mc.mc_busy_in) state_d = IF_REQ;
                IF_REQ:  if (mc.mc_take_in)          state_d = IF_WAIT;
                IF_WAIT: if (fill_accept)            state_d = IF_IDLE;
                default:                             state_d = IF_IDLE;
            endcase
        end
    end

    // Output/datapath next values; stall freezes PC and IF/ID but not the miss path.
    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        if_req_d      = if_req_q;
        if_addr_d     = if_addr_q;
        inst_flush_d  = 1'b0;
        if_id_valid_d = stall_in ? if_id_valid_q : 1'b0;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if (branch_flag_in) begin
            pc_d          = branch_target_in;
            if_id_valid_d = 1'b0;
            if_req_d      = 1'b0;
            inst_flush_d  = (state_q == IF_WAIT) ||
                            ((state_q == IF_REQ) && mc.mc_take_in);
        end else begin
            case (state_q)
                IF_IDLE: begin
                    if (hit) begin
                        if (!stall_in) begin
                            if_id_valid_d = 1'b1;
                            if_id_pc_d    = pc_q;
                            if_id_inst_d  = line_inst;
                            pc_d          = pc_next(pc_q);
                        end
                    end else if (!mc.mc_busy_in) begin
                        if_req_d  = 1'b1;
                        if_addr_d = pc_q;
                        req_pc_d  = pc_q;
                    end
                end
                IF_REQ: if (mc.mc_take_in) if_req_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Registered outputs and PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RST_PC;
            req_pc_q      <= ZERO_WORD;
            if_req_q      <= 1'b0;
            if_addr_q     <= ZERO_WORD;
            inst_flush_q  <= 1'b0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= ZERO_WORD;
            if_id_inst_q  <= ZERO_WORD;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            if_req_q      <= if_req_d;
            if_addr_q     <= if_addr_d;
            inst_flush_q  <= inst_flush_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
        end
    end

    assign mc.if_req_out     = if_req_q;
    assign mc.if_addr_out    = if_addr_q;
    assign mc.inst_flush_out = inst_flush_q;
    assign if_id_valid_out   = if_id_valid_q;
    assign if_id_pc_out      = if_id_pc_q;
    assign if_id_inst_out    = if_id_inst_q;

endmodule

// File: tb/tb_if_fetch_icache.sv
// tb/tb_if_fetch_icache.sv - randomized self-checking bench for if_fetch_icache
module tb_if_fetch_icache;
    import if_fetch_icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    if_fetch_icache_if mif ();

    if_fetch_icache #(.IDX_W(7), .RST_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_in         (stall),
        .branch_flag_in   (branch),
        .branch_target_in (target),
        .mc               (mif),
        .if_id_valid_out  (if_id_valid),
        .if_id_pc_out     (if_id_pc),
        .if_id_inst_out   (if_id_inst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) & 32'd127);
    endfunction

    // memctrl stand-in: accepts when idle, returns after lat_cfg cycles, aborts on flush
    logic        mc_active;
    int          mc_cnt;
    logic [31:0] mc_addr;
    logic        mc_fresh;
    logic        busy_force;
    logic        data_win;
    int          lat_cfg;

    assign mif.mc_busy_in = mc_active | busy_force;
    assign mif.mc_take_in = mif.if_req_out & ~mc_active & ~busy_force & ~data_win;

    always @(posedge clk) begin
        if (rst) begin
            mc_active            <= 1'b0;
            mc_cnt               <= 0;
            mc_addr              <= 32'h0;
            mc_fresh             <= 1'b0;
            mif.mc_inst_valid_in <= 1'b0;
            mif.mc_pc_in         <= 32'h0;
            mif.mc_inst_in       <= 32'h0;
        end else begin
            mc_fresh <= 1'b0;
            if (mc_active) begin
                if (mif.inst_flush_out) begin
                    mc_active <= 1'b0;
                end else if (mc_cnt <= 1) begin
                    mc_active            <= 1'b0;
                    mif.mc_inst_valid_in <= 1'b1;
                    mif.mc_pc_in         <= mc_addr;
                    mif.mc_inst_in       <= mem_word(mc_addr);
                    mc_fresh             <= 1'b1;
                end else begin
                    mc_cnt <= mc_cnt - 1;
                end
            end else if (mif.mc_take_in) begin
                mc_active <= 1'b1;
                mc_addr   <= mif.if_addr_out;
                mc_cnt    <= lat_cfg;
            end
        end
    end

    // Reference model: program-order fetch stream plus a slot->address cache map
    logic        p_rst, p_stall, p_branch, p_busy, p_take, p_ivalid;
    logic [31:0] p_target, p_mcpc;
    bit          have_prev = 1'b0;
    bit [31:0]   exp_pc;
    bit          pend, taken;
    bit          e_valid, e_req, e_flush;
    bit [31:0]   e_pc, e_inst, e_addr;
    bit [31:0]   line_of [int];

    task automatic model_step();
        bit hit;
        if (p_rst) begin
            line_of.delete();
            exp_pc = 32'h0; pend = 1'b0; taken = 1'b0;
            e_valid = 1'b0; e_req = 1'b0; e_flush = 1'b0;
            e_pc = 32'h0; e_inst = 32'h0; e_addr = 32'h0;
        end else begin
            hit = line_of.exists(slot(exp_pc)) && (line_of[slot(exp_pc)] == exp_pc);
            e_flush = 1'b0;
            if (p_branch) begin
                e_flush = pend && (taken || p_take);
                pend = 1'b0; taken = 1'b0; e_req = 1'b0; e_valid = 1'b0;
                exp_pc = p_target;
            end else if (!pend) begin
                if (hit) begin
                    if (!p_stall) begin
                        e_valid = 1'b1; e_pc = exp_pc; e_inst = mem_word(exp_pc);
                        exp_pc = exp_pc + 32'd4;
                    end
                end else begin
                    if (!p_stall) e_valid = 1'b0;
                    if (!p_busy) begin
                        pend = 1'b1; taken = 1'b0; e_req = 1'b1; e_addr = exp_pc;
                    end
                end
            end else begin
                if (!p_stall) e_valid = 1'b0;
                if (!taken) begin
                    if (p_take) begin taken = 1'b1; e_req = 1'b0; end
                end else if (p_ivalid && (p_mcpc == e_addr)) begin
                    line_of[slot(e_addr)] = e_addr;
                    pend = 1'b0;
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (have_prev) begin
            model_step();
            chk("if_id_valid", 32'(if_id_valid), 32'(e_valid));
            if (e_valid || p_rst) begin
                chk("if_id_pc", if_id_pc, e_pc);
                chk("if_id_inst", if_id_inst, e_inst);
            end
            chk("if_req", 32'(mif.if_req_out), 32'(e_req));
            if (e_req || p_rst) chk("if_addr", mif.if_addr_out, e_addr);
            chk("inst_flush", 32'(mif.inst_flush_out), 32'(e_flush));
        end
        p_rst = rst; p_stall = stall; p_branch = branch; p_target = target;
        p_busy = mif.mc_busy_in; p_take = mif.mc_take_in;
        p_ivalid = mif.mc_inst_valid_in; p_mcpc = mif.mc_pc_in;
        have_prev = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input int budget);
        for (int i = 0; i < budget && !mif.if_req_out; i++) step();
        chk({tag, "_req"}, 32'(mif.if_req_out), 32'd1);
        chk({tag, "_addr"}, mif.if_addr_out, addr);
    endtask

    task automatic wait_valid_pc(input string tag, input logic [31:0] pcv, input int budget);
        for (int i = 0; i < budget && !(if_id_valid && if_id_pc == pcv); i++) step();
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd1);
        chk({tag, "_pc"}, if_id_pc, pcv);
        chk({tag, "_inst"}, if_id_inst, mem_word(pcv));
    endtask

    task automatic redirect(input logic [31:0] t);
        branch = 1'b1; target = t;
        step();
        branch = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
        busy_force = 1'b0; data_win = 1'b0; lat_cfg = 2;
        repeat (3) step();
        rst = 1'b0;

        // cold start at pc 0
        wait_req("t1", 32'h0, 10);
        wait_valid_pc("t1", 32'h0, 20);
        chk("t1_inst_13", if_id_inst, 32'h0000_0013);
        step();
        chk("t1_next_req", 32'(mif.if_req_out), 32'd1);
        chk("t1_next_addr", mif.if_addr_out, 32'h4);

        // loop 0x0..0xC twice; second pass all hits
        wait_valid_pc("t2_first", 32'hC, 80);
        redirect(32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_valid", 32'(if_id_valid), 32'd1);
            chk("t2_pc", if_id_pc, 32'(k * 4));
            chk("t2_noreq", 32'(mif.if_req_out), 32'd0);
        end

        // miss held off by mc_busy
        busy_force = 1'b1;
        redirect(32'h40);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_busy_noreq", 32'(mif.if_req_out), 32'd0);
        end
        busy_force = 1'b0;
        step();
        chk("t3_req", 32'(mif.if_req_out), 32'd1);
        chk("t3_addr", mif.if_addr_out, 32'h40);
        wait_valid_pc("t3", 32'h40, 30);

        // branch in WAIT coinciding with the fill
        lat_cfg = 3;
        redirect(32'h80);
        wait_req("t4", 32'h80, 10);
        for (int i = 0; i < 20 && !mc_fresh; i++) step();
        chk("t4_fill_seen", 32'(mc_fresh), 32'd1);
        branch = 1'b1; target = 32'h100;
        step();
        branch = 1'b0;
        chk("t4_flush_on", 32'(mif.inst_flush_out), 32'd1);
        step();
        chk("t4_flush_off", 32'(mif.inst_flush_out), 32'd0);
        wait_req("t4_new", 32'h100, 10);
        wait_valid_pc("t4_new", 32'h100, 30);
        redirect(32'h80);
        wait_req("t4_not_written", 32'h80, 10);
        wait_valid_pc("t4_old", 32'h80, 30);

        // stall on a hit
        redirect(32'h0);
        step();
        chk("t5_pc0", if_id_pc, 32'h0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_hold_valid", 32'(if_id_valid), 32'd1);
            chk("t5_hold_pc", if_id_pc, 32'h0);
            chk("t5_hold_inst", if_id_inst, 32'h0000_0013);
        end
        stall = 1'b0;
        step();
        chk("t5_release_pc", if_id_pc, 32'h4);
        chk("t5_release_inst", if_id_inst, mem_word(32'h4));

        // aliasing lines 0x000 / 0x200
        for (int r = 0; r < 4; r++) begin
            logic [31:0] t;
            t = r[0] ? 32'h0 : 32'h200;
            redirect(t);
            wait_req("t6", t, 10);
            wait_valid_pc("t6", t, 30);
        end

        // randomized traffic including wrap-around targets and a mid-run reset
        for (int n = 0; n < 2500; n++) begin
            stall      = ($urandom_range(0, 3) == 0);
            busy_force = ($urandom_range(0, 9) == 0);
            data_win   = ($urandom_range(0, 4) == 0);
            lat_cfg    = $urandom_range(1, 4);
            branch     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) target = 32'hFFFF_FFF8;
            else target = ($urandom_range(0, 31) << 2) + ($urandom_range(0, 2) << 9);
            rst = (n == 1200);
            step();
        end
        rst = 1'b0; stall = 1'b0; branch = 1'b0; busy_force = 1'b0; data_win = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
